// File: rtl/uart_byte_receiver.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling FSM, and a
// registered output stage that presents each good byte with a one-cycle strobe.
module uart_byte_receiver #(
  parameter int RECEIVER_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  output logic [7:0] out,
  output logic       valid,
  output logic       framing_error
);

  localparam int H  = RECEIVER_PERIOD;
  localparam int CW = $clog2(2 * H) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2 * H - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      idx, idx_d;
  logic [7:0]      shift, shift_d;
  logic            pend_ok, pend_ok_d;
  logic            pend_err, pend_err_d;
  logic            sync1, s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
    end else begin
      sync1 <= in;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      pend_ok  <= 1'b0;
      pend_err <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      shift    <= shift_d;
      pend_ok  <= pend_ok_d;
      pend_err <= pend_err_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    idx_d      = idx;
    shift_d    = shift;
    pend_ok_d  = 1'b0;
    pend_err_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (!s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_d = '0;
          if (!s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_d        = '0;
          shift_d[idx] = s;
          if (idx == 3'd7) state_d = STOP;
          else             idx_d   = idx + 3'd1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (cnt == FULL_LAST) begin
          cnt_d = '0;
          if (s) begin
            pend_ok_d = 1'b1;
            state_d   = IDLE;
          end else begin
            pend_err_d = 1'b1;
            state_d    = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: strobes land one cycle after the stop-bit sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out           <= 8'h00;
      valid         <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      valid         <= pend_ok;
      framing_error <= pend_err;
      if (pend_ok) out <= shift;
    end
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver: a fast (H=2) and a slow (H=646) instance,
// table vectors, hand-written corner sequences and random frames vs a model.
module tb_uart_byte_receiver;

  localparam int H_F = 2;
  localparam int H_S = 646;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_f, in_s;
  logic [7:0] out_f, out_s;
  logic       v_f, fe_f, v_s, fe_s;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  // {kind(1=framing error), data} and the cycle at which the strobe is due
  logic [8:0] exp_q_f[$];
  logic [8:0] exp_q_s[$];
  int         cyc_q_f[$];
  int         cyc_q_s[$];
  logic [7:0] lg_f = 8'h00;
  logic [7:0] lg_s = 8'h00;

  uart_byte_receiver #(.RECEIVER_PERIOD(H_F)) dut_f (
    .clk(clk), .rst_n(rst_n), .in(in_f),
    .out(out_f), .valid(v_f), .framing_error(fe_f)
  );

  uart_byte_receiver #(.RECEIVER_PERIOD(H_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .in(in_s),
    .out(out_s), .valid(v_s), .framing_error(fe_s)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int id, input logic kind, input logic [7:0] data,
                            input int due);
    if (id == 0) begin
      exp_q_f.push_back({kind, data});
      cyc_q_f.push_back(due);
    end else begin
      exp_q_s.push_back({kind, data});
      cyc_q_s.push_back(due);
    end
  endtask

  task automatic on_strobe(input int id, input logic v, input logic fe, input logic [7:0] o);
    logic [8:0] e;
    int         ec;
    logic       empty;
    chk("strobe_exclusive", int'(v && fe), 0);
    empty = (id == 0) ? (exp_q_f.size() == 0) : (exp_q_s.size() == 0);
    if (empty) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe: dut %0d valid=%0b ferr=%0b out=%0h, expected no strobe (cycle %0d)",
               id, v, fe, o, cyc);
      return;
    end
    if (id == 0) begin
      e  = exp_q_f.pop_front();
      ec = cyc_q_f.pop_front();
      if (!e[8]) lg_f = e[7:0];
      chk("strobe_kind_f", int'(fe), int'(e[8]));
      chk("strobe_cycle_f", cyc, ec);
      chk("out_f", int'(o), int'(lg_f));
    end else begin
      e  = exp_q_s.pop_front();
      ec = cyc_q_s.pop_front();
      if (!e[8]) lg_s = e[7:0];
      chk("strobe_kind_s", int'(fe), int'(e[8]));
      chk("strobe_cycle_s", cyc, ec);
      chk("out_s", int'(o), int'(lg_s));
    end
  endtask

  always @(negedge clk) if (rst_n && (v_f || fe_f)) on_strobe(0, v_f, fe_f, out_f);
  always @(negedge clk) if (rst_n && (v_s || fe_s)) on_strobe(1, v_s, fe_s, out_s);

  // ---------------- reference model ----------------
  // Decodes the ten line levels of a frame as sampled at mid-bit.
  task automatic model_frame(input logic [9:0] levels, output logic has_evt,
                             output logic kind, output logic [7:0] data);
    has_evt = (levels[0] == 1'b0);
    data    = levels[8:1];
    kind    = (levels[9] == 1'b0);
  endtask

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic drive_bit(input int id, input logic v);
    if (id == 0) in_f = v; else in_s = v;
    repeat (2 * ((id == 0) ? H_F : H_S)) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int id, input int n);
    if (id == 0) in_f = 1'b1; else in_s = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int id, input logic [7:0] b, input logic stop,
                            input int gap, input int tail_low);
    drive_bit(id, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(id, b[k]);
    drive_bit(id, stop);
    if (tail_low > 0) begin
      if (id == 0) in_f = 1'b0; else in_s = 1'b0;
      repeat (tail_low) begin
        @(posedge clk);
        #1;
      end
    end
    idle_cycles(id, gap);
  endtask

  // Strobe lands at first-low-sample edge + 2 (sync) + 19H + 1.
  function automatic int due_cycle(input int start, input int h);
    return start + 19 * h + 4;
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_valid;
    logic       exp_ferr;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int         c;
    logic [7:0] rb;
    logic       rstop, has_evt, kind;
    logic [7:0] mdata;

    vecs[0] = '{8'h55, 1'b1, 4, 1'b1, 1'b0, 8'h55};
    vecs[1] = '{8'h41, 1'b1, 0, 1'b1, 1'b0, 8'h41};
    vecs[2] = '{8'h0A, 1'b1, 0, 1'b1, 1'b0, 8'h0A};
    vecs[3] = '{8'hFF, 1'b1, 6, 1'b1, 1'b0, 8'hFF};
    vecs[4] = '{8'h00, 1'b0, 6, 1'b0, 1'b1, 8'hFF};
    vecs[5] = '{8'h80, 1'b1, 3, 1'b1, 1'b0, 8'h80};
    vecs[6] = '{8'h01, 1'b0, 4, 1'b0, 1'b1, 8'h80};

    in_f  = 1'b1;
    in_s  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_f", int'(out_f), 0);
    chk("reset_valid_f", int'(v_f), 0);
    chk("reset_ferr_f", int'(fe_f), 0);
    chk("reset_out_s", int'(out_s), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles(0, 5);

    // Table vectors, including back-to-back 41/0A/FF with one stop bit.
    for (int i = 0; i < 7; i++) begin
      c = cyc;
      expect_evt(0, vecs[i].exp_ferr, vecs[i].data, due_cycle(c, H_F));
      send_frame(0, vecs[i].data, vecs[i].stop, vecs[i].gap, 0);
      if (vecs[i].exp_ferr) begin
        repeat (6) @(posedge clk);
        #1;
        chk("table_out_hold", int'(out_f), int'(vecs[i].exp_out));
      end
    end
    idle_cycles(0, 8);
    chk("table_last_out", int'(out_f), 8'h80);

    // Quarter-bit low glitch on an idle line, then a real frame.
    in_f = 1'b0;
    @(posedge clk);
    #1;
    idle_cycles(0, 20);
    c = cyc;
    expect_evt(0, 1'b0, 8'h3C, due_cycle(c, H_F));
    send_frame(0, 8'h3C, 1'b1, 8, 0);

    // Framing error followed by a 5-bit-time break, then 0x7E.
    c = cyc;
    expect_evt(0, 1'b1, 8'h00, due_cycle(c, H_F));
    send_frame(0, 8'h00, 1'b0, 6, 10 * H_F);
    chk("break_out_hold", int'(out_f), 8'h3C);
    c = cyc;
    expect_evt(0, 1'b0, 8'h7E, due_cycle(c, H_F));
    send_frame(0, 8'h7E, 1'b1, 8, 0);

    // Reset in the middle of DATA of 0xA5 (start + three data bits sent).
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_out", int'(out_f), 0);
    chk("midreset_valid", int'(v_f), 0);
    chk("midreset_ferr", int'(fe_f), 0);
    in_f = 1'b1;
    lg_f = 8'h00;
    lg_s = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles(0, 6);
    c = cyc;
    expect_evt(0, 1'b0, 8'hC3, due_cycle(c, H_F));
    send_frame(0, 8'hC3, 1'b1, 8, 0);

    // Random frames checked against the model.
    for (int i = 0; i < 40; i++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 4) != 0);
      model_frame({rstop, rb, 1'b0}, has_evt, kind, mdata);
      c = cyc;
      if (has_evt) expect_evt(0, kind, mdata, due_cycle(c, H_F));
      send_frame(0, rb, rstop, rstop ? $urandom_range(0, 5) : $urandom_range(2, 6), 0);
    end
    idle_cycles(0, 50);

    // Slow instance: 1292-cycle bit period.
    c = cyc;
    expect_evt(1, 1'b0, 8'h9D, due_cycle(c, H_S));
    send_frame(1, 8'h9D, 1'b1, 200, 0);
    idle_cycles(1, 50);

    chk("pending_f", exp_q_f.size(), 0);
    chk("pending_s", exp_q_s.size(), 0);
    chk("final_out_s", int'(out_s), 8'h9D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
